seven_seg_scanner: RTL
======================

Name: seven_seg_scanner

Overview:
Parametrised multiplexed seven-segment display driver for the SoC's `an`/`a_to_g` pins. It generalises the fixed 8-anode display path to NUM_DIGITS digits and adds the following:
- a programmable refresh divider;
- per-digit blanking and decimal points;
- ghost-suppression guard time;
- tear-free double-buffered updates, committed only at frame boundaries.

It sits between the memory-mapped display register (CPU side) and the board pins.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (2..16)
REFRESH_DIV, 50000, clk cycles each digit is held (>= 2)
GUARD_CYCLES, 16, cycles at start of each digit slot with all anodes off (< REFRESH_DIV)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
wr_en  input  1  load shadow buffer this cycle
wr_data  input  4*NUM_DIGITS  hex nibbles; nibble i -> digit i (digit 0 = rightmost)
wr_blank  input  NUM_DIGITS  1 = digit i blank, loaded with wr_en
wr_dp  input  NUM_DIGITS  1 = decimal point i lit, loaded with wr_en
an  output  NUM_DIGITS  anode enables, active-low, one-hot-low when active
a_to_g  output  7  segments, active-low, bit6 = a ... bit0 = g
dp  output  1  decimal point, active-low
frame_done  output  1  one-cycle pulse when the last digit slot ends
pending  output  1  shadow holds data not yet committed

Behaviour:
- Reset (rst low, async):
  - cnt = 0, digit_idx = 0
  - shadow and display buffers (data/blank/dp) = 0
  - pending = 0, frame_done = 0
  - an = all ones, a_to_g = 7'h7F, dp = 1
  - Reset mid-frame aborts the scan immediately, and uncommitted shadow data is lost.
- Divider: cnt counts 0..REFRESH_DIV-1 and wraps. tick = (cnt == REFRESH_DIV-1).
- On tick:
  - digit_idx increments; from NUM_DIGITS-1 it wraps to 0.
  - On the wrap, frame_done = 1 for exactly that next cycle.
  - On the wrap, if pending = 1: display buffers <= shadow, pending <= 0.
- Write:
  - wr_en = 1 loads data/blank/dp into shadow and sets pending = 1.
  - With multiple writes in one frame, the last write wins.
  - If wr_en coincides with the commit cycle, the commit takes the pre-write shadow. The new write lands in shadow and pending stays 1, so it commits at the next frame end.
- Outputs are registered; all outputs change 1 cycle after the cnt/digit_idx state they reflect.
  - Guard: while cnt < GUARD_CYCLES, an = all ones. a_to_g/dp already show the new digit.
  - Otherwise an[digit_idx] = 0 and all other anodes = 1.
  - A blanked digit gives a_to_g = 7'h7F and dp = 1; its anode is still driven, so scan timing is uniform.
- Decode (active-low):
  - 0=7'h01, 1=7'h4F, 2=7'h12, 3=7'h06
  - 4=7'h4C, 5=7'h24, 6=7'h20, 7=7'h0F
  - 8=7'h00, 9=7'h04, A=7'h08, b=7'h60
  - C=7'h31, d=7'h42, E=7'h30, F=7'h38
- Full frame period = NUM_DIGITS*REFRESH_DIV cycles.
- An update becomes visible at most 2 frames + 1 cycle after wr_en.

Optional Feature:
Macro: SEVEN_SEG_LZ_BLANK_EN.
- Defined: leading-zero suppression on the committed display buffer.
  - Any digit i > 0 is treated as blanked when it and all higher digits are 0 and have dp clear.
  - Digit 0 is never auto-blanked.
  - Evaluated combinationally from the display buffer, so the output latency is unchanged.
- Undefined: zeros are displayed literally and no suppression logic is generated.

Decomposition:
- Package seg_pkg:
  - localparam array SEG_LUT[16] of the active-low patterns above.
  - SEG_BLANK = 7'h7F.
  - typedef digit_t = logic [3:0].
- Sub-module hex_to_7seg (combinational, digit_t -> 7-bit via SEG_LUT), instantiated once for the selected digit.
- Divider, scan index, double buffer and the optional LZ logic stay in the top module.

Test Plan:
All tests use NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1.
1. Reset: hold rst low 3 cycles, release; write nothing.
   -> an = 4'hF, a_to_g = 7'h7F, dp = 1 during reset.
   -> Then an cycles 4'hE, 4'hD, 4'hB, 4'h7 (each low for 3 of 4 cycles) showing 7'h01.
   -> frame_done pulses every 16 cycles.
2. Write wr_data = 16'h1A3F, wr_blank = 0, wr_dp = 4'b0010 mid-frame.
   -> pending = 1 until the next frame_done; display is unchanged until then.
   -> Next frame shows digit0 = 7'h38, digit1 = 7'h06 with dp = 0, digit2 = 7'h08, digit3 = 7'h4F.
3. Pulse wr_en in the exact commit cycle with 16'h0005 after a prior pending 16'h1111.
   -> The frame shows 1111; pending stays 1; the following frame shows 0005.
4. Write wr_blank = 4'b1010.
   -> While digits 1 and 3 are scanned, a_to_g = 7'h7F, dp = 1 and their anode is still low.
5. Assert rst low mid-slot while the display shows 1234.
   -> Outputs return to reset values asynchronously (same delta, before the next clk edge).
   -> After release, the display shows 0000 and pending = 0.
6. With SEVEN_SEG_LZ_BLANK_EN defined, write 16'h0040.
   -> Digits 3 and 2 show 7'h7F; digit1 = 7'h4C; digit0 = 7'h01.
   -> With the macro undefined, digits 3 and 2 show 7'h01.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared digit type and active-low seven-segment patterns for the display scanner
package seg_pkg;
    typedef logic [3:0] digit_t;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,
        7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60,
        7'h31, 7'h42, 7'h30, 7'h38
    };
endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational hex nibble to active-low segment pattern (bit6 = a ... bit0 = g)
//   digit_i : hex nibble to show
//   seg_o   : active-low segment drive
module hex_to_7seg
    import seg_pkg::*;
(
    input  digit_t     digit_i,
    output logic [6:0] seg_o
);
    assign seg_o = SEG_LUT[digit_i];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed seven-segment driver with refresh divider, guard time and frame-synchronous double buffer
//   clk, rst (async active-low)
//   wr_en/wr_data/wr_blank/wr_dp : load shadow buffer (nibble i -> digit i, digit 0 rightmost)
//   an (active-low one-hot), a_to_g (active-low, bit6 = a), dp (active-low) : registered pin drive
//   frame_done : one-cycle pulse after the last digit slot ends
//   pending    : shadow holds data not yet committed
//   Optional macro SEVEN_SEG_LZ_BLANK_EN enables leading-zero suppression on the displayed buffer.
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   wr_blank,
    input  logic [NUM_DIGITS-1:0]   wr_dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              a_to_g,
    output logic                    dp,
    output logic                    frame_done,
    output logic                    pending
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] sh_data_q, disp_data_q;
    logic [NUM_DIGITS-1:0]   sh_blank_q, disp_blank_q, sh_dp_q, disp_dp_q, blank_eff;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              seg_q, seg_dec;
    logic                    dp_q, fd_q, pending_q, tick, wrap;
    digit_t                  digit;

    assign tick  = cnt_q == CW'(REFRESH_DIV - 1);
    assign wrap  = tick && idx_q == IW'(NUM_DIGITS - 1);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;
    assign idx_d = tick ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
    assign digit = disp_data_q[{idx_q, 2'b00} +: 4];

`ifdef SEVEN_SEG_LZ_BLANK_EN
    // A digit is suppressed while it and every digit above it are zero without a dot; digit 0 always shows.
    logic lz_run;
    always_comb begin
        blank_eff = disp_blank_q;
        lz_run    = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz_run       = lz_run & (disp_data_q[4*i +: 4] == 4'h0) & ~disp_dp_q[i];
            blank_eff[i] = blank_eff[i] | lz_run;
        end
    end
`else
    assign blank_eff = disp_blank_q;
`endif

    hex_to_7seg u_dec (.digit_i(digit), .seg_o(seg_dec));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            sh_data_q    <= '0;
            sh_blank_q   <= '0;
            sh_dp_q      <= '0;
            disp_data_q  <= '0;
            disp_blank_q <= '0;
            disp_dp_q    <= '0;
            pending_q    <= 1'b0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            fd_q         <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            if (wr_en) begin
                sh_data_q  <= wr_data;
                sh_blank_q <= wr_blank;
                sh_dp_q    <= wr_dp;
            end
            // Commit copies the pre-write shadow; a write in the commit cycle stays pending for the next frame.
            if (wrap && pending_q) begin
                disp_data_q  <= sh_data_q;
                disp_blank_q <= sh_blank_q;
                disp_dp_q    <= sh_dp_q;
            end
            pending_q <= wr_en | (pending_q & ~wrap);
            an_q      <= cnt_q < CW'(GUARD_CYCLES) ? '1 : ~(NUM_DIGITS'(1) << idx_q);
            seg_q     <= blank_eff[idx_q] ? SEG_BLANK : seg_dec;
            dp_q      <= blank_eff[idx_q] | ~disp_dp_q[idx_q];
            fd_q      <= wrap;
        end
    end

    assign an         = an_q;
    assign a_to_g     = seg_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;
    assign pending    = pending_q;
endmodule
